// File: rtl/spi_master_pkg.sv
// rtl/spi_master_pkg.sv - shared types and constants for the SPI master datapath
package spi_master_pkg;

    localparam int SPI_DATA_W  = 32;
    localparam int SPI_CNT_W   = 16;
    localparam int STEP_SINGLE = 1;
    localparam int STEP_QUAD   = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TRANSMIT = 2'd1,
        STALL    = 2'd2
    } tx_state_e;

endpackage

// File: rtl/spi_master_tx.sv
// rtl/spi_master_tx.sv - SPI master transmit shifter, single/quad lanes, FIFO-fed
module spi_master_tx
    import spi_master_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W,
    parameter int CNT_W  = SPI_CNT_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic              tx_edge,
    output logic              tx_done,
    output logic              sdo0,
    output logic              sdo1,
    output logic              sdo2,
    output logic              sdo3,
    input  logic              en_quad_in,
    input  logic [CNT_W-1:0]  counter_in,
    input  logic              counter_in_upd,
    input  logic [DATA_W-1:0] data,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              clk_en_o
);

    tx_state_e         state;
    logic [DATA_W-1:0] shift;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  word_cnt;
    logic [CNT_W-1:0]  len_trgt;
    logic              quad_q;

    logic [CNT_W-1:0]  len_cur;
    logic [CNT_W-1:0]  eff_len;
    logic [CNT_W-1:0]  step;
    logic [CNT_W-1:0]  bit_nxt;
    logic [CNT_W-1:0]  word_nxt;
    logic              quad_sel;
    logic              last_beat;
    logic              word_end;

    // In IDLE the pending request's mode/length decide the start; afterwards the latched mode rules.
    always_comb begin
        len_cur   = counter_in_upd ? counter_in : len_trgt;
        quad_sel  = (state == IDLE) ? en_quad_in : quad_q;
        eff_len   = quad_sel ? (len_cur & ~CNT_W'(3)) : len_cur;
        step      = quad_sel ? CNT_W'(STEP_QUAD) : CNT_W'(STEP_SINGLE);
        bit_nxt   = bit_cnt + step;
        word_nxt  = word_cnt + step;
        last_beat = (bit_nxt == eff_len);
        word_end  = (word_nxt == CNT_W'(DATA_W));
    end

    always_comb begin
        data_ready = 1'b0;
        case (state)
            IDLE:     data_ready = en && (eff_len != '0) && data_valid;
            TRANSMIT: data_ready = tx_edge && !last_beat && word_end && data_valid;
            STALL:    data_ready = data_valid;
            default:  data_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            shift    <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            quad_q   <= 1'b0;
            len_trgt <= CNT_W'(DATA_W);
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (counter_in_upd) begin
                len_trgt <= counter_in;
            end
            case (state)
                IDLE: begin
                    if (en) begin
                        if (eff_len == '0) begin
                            tx_done <= 1'b1;
                        end else if (data_valid) begin
                            shift    <= data;
                            quad_q   <= en_quad_in;
                            bit_cnt  <= '0;
                            word_cnt <= '0;
                            state    <= TRANSMIT;
                        end
                    end
                end
                TRANSMIT: begin
                    if (tx_edge) begin
                        shift    <= quad_q ? {shift[DATA_W-5:0], 4'b0000}
                                           : {shift[DATA_W-2:0], 1'b0};
                        bit_cnt  <= bit_nxt;
                        word_cnt <= word_nxt;
                        if (last_beat) begin
                            tx_done <= 1'b1;
                            state   <= IDLE;
                        end else if (word_end) begin
                            // Reload in the same cycle so back-to-back words leave no gap.
                            if (data_valid) begin
                                shift    <= data;
                                word_cnt <= '0;
                            end else begin
                                state <= STALL;
                            end
                        end
                    end
                end
                STALL: begin
                    if (data_valid) begin
                        shift    <= data;
                        word_cnt <= '0;
                        state    <= TRANSMIT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign clk_en_o = (state == TRANSMIT);
    assign sdo0     = quad_q ? shift[DATA_W-4] : shift[DATA_W-1];
    assign sdo1     = quad_q & shift[DATA_W-3];
    assign sdo2     = quad_q & shift[DATA_W-2];
    assign sdo3     = quad_q & shift[DATA_W-1];

endmodule

// File: tb/tb_spi_master_tx.sv
// tb/tb_spi_master_tx.sv - directed scoreboard bench for spi_master_tx
module tb_spi_master_tx;

    logic        clk;
    logic        rstn;
    logic        en;
    logic        tx_edge;
    logic        tx_done;
    logic        sdo0, sdo1, sdo2, sdo3;
    logic        en_quad_in;
    logic [15:0] counter_in;
    logic        counter_in_upd;
    logic [31:0] data;
    logic        data_valid;
    logic        data_ready;
    logic        clk_en_o;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [3:0]  exp_q[$];
    logic [31:0] words[0:1];

    spi_master_tx dut (
        .clk            (clk),
        .rstn           (rstn),
        .en             (en),
        .tx_edge        (tx_edge),
        .tx_done        (tx_done),
        .sdo0           (sdo0),
        .sdo1           (sdo1),
        .sdo2           (sdo2),
        .sdo3           (sdo3),
        .en_quad_in     (en_quad_in),
        .counter_in     (counter_in),
        .counter_in_upd (counter_in_upd),
        .data           (data),
        .data_valid     (data_valid),
        .data_ready     (data_ready),
        .clk_en_o       (clk_en_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    // One transfer: pushes expected beats, then drives edges and pops/compares each beat.
    task automatic xfer(input bit quad, input int len, input bit upd,
                        input int stall_word, input int stall_cyc, input int abort_at);
        int         stp, eff, nbeats, p, w, k;
        bit         we, last, hold;
        logic [3:0] beat;
        stp    = quad ? 4 : 1;
        eff    = quad ? (len & ~3) : len;
        nbeats = eff / stp;
        for (int b = 0; b < nbeats; b++) begin
            p = b * stp;
            w = p / 32;
            k = p % 32;
            if (quad) beat = 4'((words[w] >> (28 - k)) & 32'hF);
            else      beat = 4'((words[w] >> (31 - k)) & 32'h1);
            exp_q.push_back(beat);
        end
        counter_in     = 16'(len);
        counter_in_upd = upd;
        en_quad_in     = quad;
        en             = 1'b1;
        data           = words[0];
        data_valid     = 1'b1;
        #1;
        check(32'(data_ready), 32'(eff != 0), "start_ready");
        step_clk();
        en             = 1'b0;
        counter_in_upd = 1'b0;
        data_valid     = 1'b0;
        en_quad_in     = ~quad;
        check(32'(clk_en_o), 32'(eff != 0), "start_clk_en");
        for (int b = 0; b < nbeats; b++) begin
            if (b == abort_at) begin
                rstn = 1'b0;
                #1;
                check(32'({tx_done, data_ready, clk_en_o}), 32'd0, "rst_ctrl");
                check(32'({sdo3, sdo2, sdo1, sdo0}), 32'd0, "rst_sdo");
                exp_q.delete();
                step_clk();
                rstn = 1'b1;
                return;
            end
            if (exp_q.size() == 0) begin
                check(32'd0, 32'd1, "scoreboard_underflow");
                beat = 4'h0;
            end else begin
                beat = exp_q.pop_front();
            end
            check(32'({sdo3, sdo2, sdo1, sdo0}), 32'(beat), $sformatf("beat%0d", b));
            last = (b == nbeats - 1);
            we   = (((b + 1) * stp) % 32) == 0;
            w    = ((b + 1) * stp) / 32;
            hold = we && !last && (w == stall_word);
            data_valid = last || (we && !hold);
            data       = (we && !last && w < 2) ? words[w] : 32'hFFFF_FFFF;
            tx_edge    = 1'b1;
            #1;
            check(32'(data_ready), 32'(we && !last && !hold), $sformatf("ready_b%0d", b));
            step_clk();
            tx_edge    = 1'b0;
            data_valid = 1'b0;
            check(32'(tx_done), 32'(last), $sformatf("done_b%0d", b));
            check(32'(clk_en_o), 32'(!(last || hold)), $sformatf("clk_en_b%0d", b));
            if (hold) begin
                check(32'(sdo0), 32'd0, "stall_sdo");
                repeat (stall_cyc) begin
                    tx_edge = 1'b1;
                    step_clk();
                    check(32'({clk_en_o, sdo0}), 32'd0, "stall_hold");
                end
                tx_edge    = 1'b0;
                data       = words[w];
                data_valid = 1'b1;
                #1;
                check(32'(data_ready), 32'd1, "stall_ready");
                step_clk();
                data_valid = 1'b0;
                check(32'(clk_en_o), 32'd1, "resume_clk_en");
            end else if (!last && (b % 3) == 2) begin
                step_clk();
            end
        end
        check(32'(exp_q.size()), 32'd0, "scoreboard_empty");
        step_clk();
        check(32'(tx_done), 32'd0, "done_pulse_end");
    endtask

    initial begin
        rstn           = 1'b0;
        en             = 1'b0;
        tx_edge        = 1'b0;
        en_quad_in     = 1'b0;
        counter_in     = 16'd0;
        counter_in_upd = 1'b0;
        data           = 32'd0;
        data_valid     = 1'b0;
        words[0]       = 32'd0;
        words[1]       = 32'd0;
        repeat (2) step_clk();
        check(32'({tx_done, data_ready, clk_en_o}), 32'd0, "reset_ctrl");
        check(32'({sdo3, sdo2, sdo1, sdo0}), 32'd0, "reset_sdo");
        rstn = 1'b1;
        step_clk();

        words[0] = 32'hA5A5_0F0F;
        xfer(1'b0, 32, 1'b1, -1, 0, -1);

        words[0] = 32'h1234_5678;
        words[1] = 32'h9ABC_DEF0;
        xfer(1'b1, 64, 1'b1, -1, 0, -1);

        words[0] = 32'hDEAD_BEEF;
        words[1] = 32'hC35A_0000;
        xfer(1'b0, 40, 1'b1, 1, 5, -1);

        counter_in     = 16'd0;
        counter_in_upd = 1'b1;
        step_clk();
        counter_in_upd = 1'b0;
        en             = 1'b1;
        data           = 32'hFFFF_FFFF;
        data_valid     = 1'b1;
        #1;
        check(32'(data_ready), 32'd0, "zero_ready");
        step_clk();
        en         = 1'b0;
        data_valid = 1'b0;
        check(32'({tx_done, clk_en_o}), 32'b10, "zero_done");
        step_clk();
        check(32'(tx_done), 32'd0, "zero_done_end");

        words[0] = 32'h5F00_0000;
        xfer(1'b1, 10, 1'b1, -1, 0, -1);

        words[0] = 32'h3C3C_3C3C;
        xfer(1'b0, 32, 1'b1, -1, 0, 10);
        words[0] = 32'h8000_0001;
        xfer(1'b0, 32, 1'b0, -1, 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_master_tx.md
Name: spi_master_tx

Overview:
Transmit half of the SPI master. It shifts 32-bit words onto sdo0..sdo3 in single or quad mode, and it is the far end of the line that the SPI slave receive path samples.
- Words arrive from the TX FIFO over a valid/ready handshake.
- Shifting is paced by tx_edge strobes from the SPI clock generator.
- clk_en_o gates that generator: it stops SCLK while idle or when the FIFO underruns.

Parameters:
DATA_W, 32, shift-register and word width (quad mode requires multiple of 4)
CNT_W, 16, width of bit-length and bit counters

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
en  in  1  start request (level), sampled in IDLE
tx_edge  in  1  one-cycle strobe from clock generator: shift one beat
tx_done  out  1  one-cycle pulse: last beat of transfer shifted
sdo0  out  1  serial data (single mode), bit 0 in quad mode
sdo1  out  1  quad-mode bit 1, 0 in single mode
sdo2  out  1  quad-mode bit 2, 0 in single mode
sdo3  out  1  quad-mode bit 3, 0 in single mode
en_quad_in  in  1  quad mode select, latched at transfer start
counter_in  in  CNT_W  transfer length in bits
counter_in_upd  in  1  load counter_in into length target
data  in  DATA_W  word from TX FIFO
data_valid  in  1  FIFO word available
data_ready  out  1  word consumed this cycle (combinational, one cycle per word)
clk_en_o  out  1  enable for SPI clock generator

Behaviour:
Reset (rstn low, asynchronous):
- state=IDLE, shift=0, bit_cnt=0, word_cnt=0, quad_q=0, len_trgt=32.
- tx_done=0, data_ready=0, clk_en_o=0, sdo0..3=0.

Length target:
- counter_in_upd=1 loads len_trgt<=counter_in in any state.
- In quad mode the effective length is len_trgt with bits[1:0] cleared.
- An update in the same cycle as start is used for that transfer (combinational bypass).

Outputs:
- Single mode: sdo0=shift[DATA_W-1].
- Quad mode: {sdo3,sdo2,sdo1,sdo0}=shift[DATA_W-1:DATA_W-4].
- sdo is driven straight from the register, so the first beat is valid before the first tx_edge.

FSM states: IDLE, TRANSMIT, STALL.

IDLE:
- clk_en_o=0.
- en=1 and effective length=0: tx_done=1 next cycle; no word consumed; stay IDLE.
- en=1 and data_valid=1: data_ready=1, shift<=data, quad_q<=en_quad_in, bit_cnt<=0, word_cnt<=0, go TRANSMIT.
- en=1 and data_valid=0: wait in IDLE.

TRANSMIT:
- clk_en_o=1.
- On tx_edge: shift left by 1 (single) or 4 (quad), zero fill. bit_cnt and word_cnt advance by 1 or 4.
- If bit_cnt+step == effective length: tx_done=1 that cycle, go IDLE. No further word is requested even if data_valid=1.
- Else if word_cnt+step == DATA_W:
  - data_valid=1: data_ready=1, shift<=data, word_cnt<=0, stay TRANSMIT (same-cycle reload, no gap).
  - data_valid=0: go STALL.
- tx_edge=0: hold all state.

STALL:
- clk_en_o=0, sdo holds its last values.
- data_valid=1: data_ready=1, load word, word_cnt<=0, return to TRANSMIT.

Fixed rules:
- en deassertion mid-transfer is ignored; the transfer always completes.
- en_quad_in changes mid-transfer are ignored (quad_q is used).
- tx_edge in IDLE or STALL is ignored.
- A partial final word leaves its unsent bits discarded.
- Arithmetic wraps are impossible while len_trgt<2^CNT_W; counters are CNT_W wide.
- Reset mid-transfer returns immediately to the reset values above.

Decomposition:
- Package spi_master_pkg holds:
  - tx_state_e enum {IDLE, TRANSMIT, STALL};
  - localparams STEP_SINGLE=1, STEP_QUAD=4;
  - DATA_W/CNT_W defaults, shared with spi_master_rx.
- No sub-module: the shift register, counters and FSM form one natural unit of about 200 lines.

Test Plan:
- Reset release, then len=32, single mode, data=0xA5A5_0F0F, 32 tx_edges.
  Required: sdo0 emits bits 31..0 MSB first; data_ready asserted once at start; tx_done on edge 32; clk_en_o falls the same cycle.
- Quad mode, len=64, words 0x1234_5678 and 0x9ABC_DEF0 both valid.
  Required: nibbles 1,2,...,8,9,...,0 on sdo3..0; second data_ready on edge 8 with no stall; tx_done on edge 16.
- Single mode, len=40, second word withheld for 5 cycles after edge 32.
  Required: STALL entered with clk_en_o=0 and sdo0 held; resume on data_valid; tx_done after 8 more edges.
- counter_in_upd with counter_in=0 then en=1.
  Required: tx_done pulse, data_ready never asserted.
- Quad mode, counter_in=10.
  Required: effective length 8; tx_done on edge 2.
- rstn asserted at edge 10 of 32.
  Required: outputs immediately at reset values; a new transfer after release starts cleanly from the first bit.
